// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer: gathers 16-word blocks, issues init/next to the SHA-256 core, latches digest.
// Optional: SHA256_BYTE_SWAP_EN byte-reverses message words into the core and digest words out.
module sha256_block_sequencer #(
    parameter int TIMEOUT_W = 8,
    parameter int IRQ_LEN   = 1
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         cfg_first,
    input  logic         cfg_irq_en,
    input  logic         cfg_abort,
    input  logic         s_wvalid,
    output logic         s_wready,
    input  logic [31:0]  s_wdata,
    input  logic         s_wlast,
    output logic         core_init,
    output logic         core_next,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic         core_digest_valid,
    input  logic [255:0] core_digest,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy,
    output logic         err_len,
    output logic         err_timeout,
    output logic         irq_hash_finish
);

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, DONE} state_t;

    state_t               state;
    logic [31:0]          blk_q [16];
    logic [3:0]           cnt;
    logic                 first_q;
    logic                 chain_ok;
    logic [TIMEOUT_W-1:0] wdog;
    logic [3:0]           irq_cnt;
    logic                 acc;
    logic                 len_bad;
    logic                 issue;
    logic [255:0]         digest_in;

    function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef SHA256_BYTE_SWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    assign acc             = s_wvalid & s_wready;
    assign len_bad         = s_wlast != (cnt == 4'd15);
    assign issue           = (state == ISSUE) & core_ready & ~cfg_abort;
    assign core_init       = issue & first_q;
    assign core_next       = issue & ~first_q;
    assign busy            = state != IDLE;
    assign irq_hash_finish = irq_cnt != 4'd0;

    for (genvar g = 0; g < 16; g++) begin : g_blk
        assign core_block[511-32*g -: 32] = sw(blk_q[g]);
    end

    for (genvar g = 0; g < 8; g++) begin : g_dig
        assign digest_in[255-32*g -: 32] = sw(core_digest[255-32*g -: 32]);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= IDLE;
            for (int i = 0; i < 16; i++) blk_q[i] <= '0;
            cnt          <= 4'd0;
            first_q      <= 1'b0;
            chain_ok     <= 1'b0;
            wdog         <= '0;
            irq_cnt      <= 4'd0;
            s_wready     <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            err_len      <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (irq_cnt != 4'd0) irq_cnt <= irq_cnt - 4'd1;
            if (cfg_abort) begin
                state       <= IDLE;
                cnt         <= 4'd0;
                chain_ok    <= 1'b0;
                err_len     <= 1'b0;
                err_timeout <= 1'b0;
                irq_cnt     <= 4'd0;
                s_wready    <= 1'b1;
            end else begin
                unique case (state)
                    IDLE, FILL: begin
                        s_wready <= 1'b1;
                        if (acc) begin
                            blk_q[cnt] <= s_wdata;
                            cnt        <= cnt + 4'd1;
                            if (cnt == 4'd0) begin
                                first_q      <= cfg_first | ~chain_ok;
                                digest_valid <= 1'b0;
                            end
                            if (len_bad) begin
                                err_len  <= 1'b1;
                                cnt      <= 4'd0;
                                chain_ok <= 1'b0;
                                state    <= IDLE;
                            end else if (cnt == 4'd15) begin
                                s_wready <= 1'b0;
                                state    <= ISSUE;
                            end else begin
                                state <= FILL;
                            end
                        end
                    end
                    ISSUE: begin
                        if (core_ready) begin
                            wdog  <= '1;
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        // a digest arriving in the expiry cycle still wins
                        if (core_digest_valid) begin
                            digest       <= digest_in;
                            digest_valid <= 1'b1;
                            chain_ok     <= 1'b1;
                            state        <= DONE;
                        end else if (wdog == TIMEOUT_W'(1)) begin
                            err_timeout <= 1'b1;
                            chain_ok    <= 1'b0;
                            s_wready    <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            wdog <= wdog - TIMEOUT_W'(1);
                        end
                    end
                    DONE: begin
                        if (cfg_irq_en) irq_cnt <= 4'(IRQ_LEN);
                        s_wready <= 1'b1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// tb_sha256_block_sequencer: directed bench for the SHA-256 block sequencer.
// Core is a small responder returning a preset digest after a set latency.
module tb_sha256_block_sequencer;

    localparam int TW = 4;
    localparam int IL = 2;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         cfg_first = 1'b0;
    logic         cfg_irq_en = 1'b0;
    logic         cfg_abort = 1'b0;
    logic         s_wvalid = 1'b0;
    logic [31:0]  s_wdata = '0;
    logic         s_wlast = 1'b0;
    logic         core_ready = 1'b0;
    logic         core_digest_valid = 1'b0;
    logic [255:0] core_digest = '0;
    logic         s_wready;
    logic         core_init;
    logic         core_next;
    logic [511:0] core_block;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
    logic         err_len;
    logic         err_timeout;
    logic         irq_hash_finish;

    int n_cmp = 0;
    int n_bad = 0;
    int n_init = 0;
    int n_next = 0;
    int n_irq = 0;
    int resp_lat = 0;
    int resp_cnt = 0;
    int n0;
    int ni;

    logic [511:0] blk_a = {
        32'h64343962, 32'h39623732, 32'h61626364, 32'h65666768,
        32'h31323334, 32'h35363738, 32'h0badc0de, 32'hdeadbeef,
        32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
        32'h11223344, 32'h55667788, 32'h99aabbcc, 32'h39656463};
    logic [511:0] blk_b = {32'h00000080, {14{32'h0}}, 32'h00020000};
    logic [255:0] dig_a =
        256'h00112233_44556677_8899aabb_ccddeeff_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    logic [255:0] dig_b =
        256'h049da052_634feb56_ce6ec0bc_648c6720_11edff1c_b272b531_13bbc90a_8f00249c;

    sha256_block_sequencer #(.TIMEOUT_W(TW), .IRQ_LEN(IL)) dut (
        .aclk(aclk), .areset(areset),
        .cfg_first(cfg_first), .cfg_irq_en(cfg_irq_en), .cfg_abort(cfg_abort),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
        .core_init(core_init), .core_next(core_next), .core_block(core_block),
        .core_ready(core_ready), .core_digest_valid(core_digest_valid),
        .core_digest(core_digest), .digest(digest), .digest_valid(digest_valid),
        .busy(busy), .err_len(err_len), .err_timeout(err_timeout),
        .irq_hash_finish(irq_hash_finish)
    );

    always #5 aclk = ~aclk;

    // core responder and event counters, evaluated mid-cycle
    always @(negedge aclk) begin
        core_digest_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) core_digest_valid = 1'b1;
        end
        if (core_init) n_init = n_init + 1;
        if (core_next) n_next = n_next + 1;
        if (irq_hash_finish) n_irq = n_irq + 1;
        if ((core_init | core_next) && resp_lat > 0) resp_cnt = resp_lat;
    end

    function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef SHA256_BYTE_SWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    function automatic logic [511:0] swb(input logic [511:0] b);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[511-32*k -: 32] = sw(b[511-32*k -: 32]);
        return r;
    endfunction

    function automatic logic [255:0] swd(input logic [255:0] d);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[255-32*k -: 32] = sw(d[255-32*k -: 32]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [511:0] blk, input int nw, input int last_at, input int abort_at);
        for (int k = 0; k < nw; k++) begin
            s_wvalid  = 1'b1;
            s_wdata   = blk[511-32*k -: 32];
            s_wlast   = (k == last_at);
            cfg_abort = (k == abort_at);
            step();
        end
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        cfg_abort = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!digest_valid && n < 40) begin
            step();
            n++;
        end
        check("done_wait", digest_valid, 1);
    endtask

    task automatic abort_pulse();
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
    endtask

    initial begin
        core_ready = 1'b1;
        cfg_first  = 1'b1;
        cfg_irq_en = 1'b1;
        resp_lat   = 2;
        core_digest = dig_a;
        #2;
        check("rst_wready", s_wready, 0);
        check("rst_busy", busy, 0);
        check("rst_digest", {digest, digest_valid}, 0);
        check("rst_flags", {err_len, err_timeout, irq_hash_finish, core_init, core_next}, 0);
        check("rst_block", core_block, 0);
        step();
        areset = 1'b0;
        step();
        step();
        check("wready_idle", s_wready, 1);

        // block A: new message
        send(blk_a, 16, 15, -1);
        check("a_init", {core_init, core_next}, 2'b10);
        check("a_block", core_block, swb(blk_a));
        check("a_wready", s_wready, 0);
        step();
        step();
        check("a_dv_early", digest_valid, 0);
        step();
        check("a_dv_lat", digest_valid, 1);
        check("a_digest", digest, swd(dig_a));
        check("a_irq_early", irq_hash_finish, 0);
        step();
        check("a_irq1", irq_hash_finish, 1);
        step();
        check("a_irq2", irq_hash_finish, 1);
        step();
        check("a_irq_end", irq_hash_finish, 0);
        check("a_counts", {8'(n_init), 8'(n_next), 8'(n_irq)}, {8'd1, 8'd0, 8'd2});

        // block B chains onto A
        cfg_first = 1'b0;
        core_digest = dig_b;
        send(blk_b, 16, 15, -1);
        check("b_next", {core_init, core_next}, 2'b01);
        check("b_dv_clr", digest_valid, 0);
        check("b_block", core_block, swb(blk_b));
        wait_done();
        check("b_digest", digest, swd(dig_b));
        repeat (4) step();
        check("b_counts", {8'(n_init), 8'(n_next), 8'(n_irq)}, {8'd1, 8'd1, 8'd4});

        // early s_wlast
        n0 = n_init + n_next;
        send(blk_a, 6, 5, -1);
        check("len_early", err_len, 1);
        check("len_wready", s_wready, 1);
        check("len_busy", busy, 0);
        repeat (3) step();
        check("len_noissue", n_init + n_next, n0);
        abort_pulse();
        check("len_abort_clr", err_len, 0);

        // missing s_wlast on word 16
        send(blk_a, 16, -1, -1);
        check("len_missing", {err_len, busy}, 2'b10);
        abort_pulse();

        // core stalls for 20 cycles
        core_ready = 1'b0;
        n0 = n_init;
        send(blk_b, 16, 15, -1);
        check("stall_hold", {core_init, core_next, busy}, 3'b001);
        repeat (20) step();
        check("stall_none", n_init + n_next, n0 + n_next);
        core_ready = 1'b1;
        #1;
        check("stall_init", core_init, 1);
        step();
        check("stall_pulse", core_init, 0);
        wait_done();
        check("stall_once", n_init, n0 + 1);

        // watchdog expiry
        resp_lat = 0;
        repeat (3) step();
        ni = n_irq;
        send(blk_a, 16, 15, -1);
        check("to_next", core_next, 1);
        repeat (15) step();
        check("to_early", {err_timeout, busy}, 2'b01);
        step();
        check("to_fire", {err_timeout, busy}, 2'b10);
        repeat (4) step();
        check("to_noirq", n_irq, ni);
        resp_lat = 2;
        core_digest = dig_a;
        n0 = n_init;
        send(blk_b, 16, 15, -1);
        check("to_reinit", {core_init, core_next}, 2'b10);
        wait_done();
        check("to_sticky", err_timeout, 1);
        check("to_init_cnt", n_init, n0 + 1);

        // abort together with word 16
        n0 = n_init + n_next;
        send(blk_a, 16, 15, 15);
        check("ab_idle", {busy, s_wready, core_init, core_next}, 4'b0100);
        check("ab_err_clr", err_timeout, 0);
        repeat (3) step();
        check("ab_noissue", n_init + n_next, n0);

        // irq disabled
        cfg_irq_en = 1'b0;
        ni = n_irq;
        send(blk_a, 16, 15, -1);
        wait_done();
        repeat (5) step();
        check("noirq_dv", digest_valid, 1);
        check("noirq_cnt", n_irq, ni);

        // reset while waiting on the core
        resp_lat = 0;
        send(blk_b, 16, 15, -1);
        step();
        step();
        check("mid_busy", busy, 1);
        areset = 1'b1;
        #1;
        check("mid_rst_state", {busy, s_wready, digest_valid, err_len, err_timeout}, 0);
        check("mid_rst_data", {core_block, digest}, 0);
        step();
        areset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
